// File: rtl/fp_div_iter_if.sv
// Operand/result handshake bundle for fp_div_iter: split-field operands in, registered result out.
// Both sides follow valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface fp_div_iter_if #(
    parameter int MANTISSA_WIDTH = 23,
    parameter int EXP_WIDTH      = 8
) ();
    logic                      in_valid;
    logic                      in_ready;
    logic                      sign_x;
    logic                      sign_y;
    logic [EXP_WIDTH-1:0]      exp_x;
    logic [EXP_WIDTH-1:0]      exp_y;
    logic [MANTISSA_WIDTH-1:0] mantissa_x;
    logic [MANTISSA_WIDTH-1:0] mantissa_y;
    logic                      out_valid;
    logic                      out_ready;
    logic                      sign_out;
    logic [EXP_WIDTH-1:0]      exp_out;
    logic [MANTISSA_WIDTH-1:0] mantissa_out;

    modport master (
        output in_valid, sign_x, sign_y, exp_x, exp_y, mantissa_x, mantissa_y, out_ready,
        input  in_ready, out_valid, sign_out, exp_out, mantissa_out
    );

    modport slave (
        input  in_valid, sign_x, sign_y, exp_x, exp_y, mantissa_x, mantissa_y, out_ready,
        output in_ready, out_valid, sign_out, exp_out, mantissa_out
    );
endinterface

// File: rtl/fp_div_iter.sv
// Iterative FP divider X/Y: one radix-2 restoring step per clock, truncating quotient,
// exponent saturation matching the FP multiplier. FSM state is visible on state_dbg.
module fp_div_iter #(
    parameter int MANTISSA_WIDTH = 23,
    parameter int EXP_WIDTH      = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    fp_div_iter_if.slave  bus,
    output logic [1:0]    state_dbg
);
    localparam int SW  = MANTISSA_WIDTH + 1;   // significand with hidden one
    localparam int RW  = MANTISSA_WIDTH + 2;   // remainder / quotient width
    localparam int CW  = $clog2(RW);
    localparam int EW2 = EXP_WIDTH + 2;
    localparam logic [EW2-1:0]       BIAS     = EW2'(2**(EXP_WIDTH-1) - 1);
    localparam logic [EW2-1:0]       EXP_OVF  = EW2'(2**EXP_WIDTH - 1);
    localparam logic [EXP_WIDTH-1:0] EXP_SAT  = EXP_WIDTH'(2**EXP_WIDTH - 2);
    localparam logic [EXP_WIDTH-1:0] EXP_MIN  = EXP_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

    state_t                    state;
    logic [CW-1:0]             cnt;
    logic [RW-1:0]             rem;
    logic [RW-1:0]             quo;
    logic [SW-1:0]             div_sig;
    logic [EXP_WIDTH-1:0]      ex_q;
    logic [EXP_WIDTH-1:0]      ey_q;
    logic                      sgn_q;

    logic                      ge;
    logic [RW-1:0]             rem_next;
    logic                      adj;
    logic [MANTISSA_WIDTH-1:0] norm_mant;
    logic [EW2-1:0]            e;
    logic                      ovf;
    logic                      unf;

    assign state_dbg = state;

    always_comb begin
        ge       = (rem >= {1'b0, div_sig});
        rem_next = ge ? (rem - {1'b0, div_sig}) : rem;
        // Quotient lies in (0.5, 2) scaled by 2^24; top bit picks the normalization shift.
        adj       = ~quo[RW-1];
        norm_mant = quo[RW-1] ? quo[RW-2:1] : quo[RW-3:0];
        e         = {2'b00, ex_q} - {2'b00, ey_q} + BIAS - EW2'(adj);
        ovf       = ~e[EW2-1] && (e >= EXP_OVF);
        unf       = e[EW2-1] || (e == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            rem              <= '0;
            quo              <= '0;
            div_sig          <= '0;
            ex_q             <= '0;
            ey_q             <= '0;
            sgn_q            <= 1'b0;
            bus.in_ready     <= 1'b1;
            bus.out_valid    <= 1'b0;
            bus.sign_out     <= 1'b0;
            bus.exp_out      <= '0;
            bus.mantissa_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        rem          <= {1'b0, 1'b1, bus.mantissa_x};
                        div_sig      <= {1'b1, bus.mantissa_y};
                        ex_q         <= bus.exp_x;
                        ey_q         <= bus.exp_y;
                        sgn_q        <= bus.sign_x ^ bus.sign_y;
                        quo          <= '0;
                        cnt          <= CW'(MANTISSA_WIDTH + 1);
                        bus.in_ready <= 1'b0;
                        state        <= CALC;
                    end
                end
                CALC: begin
                    quo <= {quo[RW-2:0], ge};
                    rem <= rem_next << 1;
                    if (cnt == '0) begin
                        state <= NORM;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                NORM: begin
                    bus.sign_out <= sgn_q;
                    if (ovf) begin
                        bus.exp_out      <= EXP_SAT;
                        bus.mantissa_out <= '1;
                    end else if (unf) begin
                        bus.exp_out      <= EXP_MIN;
                        bus.mantissa_out <= '0;
                    end else begin
                        bus.exp_out      <= e[EXP_WIDTH-1:0];
                        bus.mantissa_out <= norm_mant;
                    end
                    bus.out_valid <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    bus.in_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fp_div_iter.sv
// Directed bench for fp_div_iter: latency, saturation boundaries, backpressure,
// mid-operation reset and back-to-back issue against a truncating division model.
module tb_fp_div_iter;
    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;
    int         n_checks;
    int         n_errors;
    int         cyc;
    bit         sb_en;
    logic [31:0] exp_q[$];

    fp_div_iter_if dut_if ();

    fp_div_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (dut_if),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] golden(input logic sx, input logic [7:0] ex, input logic [22:0] mx,
                                           input logic sy, input logic [7:0] ey, input logic [22:0] my);
        logic [47:0] num;
        logic [47:0] den;
        logic [47:0] q48;
        logic [24:0] q;
        logic [22:0] m;
        int          e;
        num = {1'b1, mx, 24'h000000};
        den = {24'h000000, 1'b1, my};
        q48 = num / den;
        q   = q48[24:0];
        if (q[24]) begin
            m = q[23:1];
            e = int'(ex) - int'(ey) + 127;
        end else begin
            m = q[22:0];
            e = int'(ex) - int'(ey) + 126;
        end
        if (e >= 255)    golden = {sx ^ sy, 8'hFE, 23'h7FFFFF};
        else if (e <= 0) golden = {sx ^ sy, 8'h01, 23'h000000};
        else             golden = {sx ^ sy, e[7:0], m};
    endfunction

    function automatic logic [31:0] result();
        result = {dut_if.sign_out, dut_if.exp_out, dut_if.mantissa_out};
    endfunction

    // driver tasks
    task automatic drive_ops(input logic sx, input logic [7:0] ex, input logic [22:0] mx,
                             input logic sy, input logic [7:0] ey, input logic [22:0] my);
        dut_if.sign_x     = sx;
        dut_if.exp_x      = ex;
        dut_if.mantissa_x = mx;
        dut_if.sign_y     = sy;
        dut_if.exp_y      = ey;
        dut_if.mantissa_y = my;
    endtask

    task automatic do_op(input string tag, input logic sx, input logic [7:0] ex, input logic [22:0] mx,
                         input logic sy, input logic [7:0] ey, input logic [22:0] my,
                         input logic [31:0] exp_res, input bit release_out);
        int n;
        drive_ops(sx, ex, mx, sy, ey, my);
        dut_if.in_valid = 1'b1;
        @(posedge clk); #1;
        dut_if.in_valid = 1'b0;
        n = 0;
        while (!dut_if.out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'd26);
        check({tag, "_res"}, 64'(result()), 64'(exp_res));
        if (release_out) begin
            dut_if.out_ready = 1'b1;
            @(posedge clk); #1;
            dut_if.out_ready = 1'b0;
            check({tag, "_idle"}, 64'(dut_if.in_ready), 64'd1);
        end
    endtask

    // scoreboard for back-to-back results
    always @(negedge clk) begin
        if (sb_en && dut_if.out_valid && dut_if.out_ready) begin
            if (exp_q.size() == 0) check("b2b_extra", 64'd1, 64'd0);
            else                   check("b2b_res", 64'(result()), 64'(exp_q.pop_front()));
        end
    end

    initial begin
        int          n;
        int          rises;
        int          acc[3];
        logic        sx, sy;
        logic [7:0]  ex, ey;
        logic [22:0] mx, my;
        n_checks = 0;
        n_errors = 0;
        sb_en    = 1'b0;
        rst_n    = 1'b0;
        dut_if.in_valid  = 1'b0;
        dut_if.out_ready = 1'b0;
        drive_ops(1'b0, 8'd0, 23'd0, 1'b0, 8'd0, 23'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  64'(dut_if.in_ready), 64'd1);
        check("rst_out_valid", 64'(dut_if.out_valid), 64'd0);
        check("rst_result",    64'(result()), 64'd0);
        check("rst_state",     64'(state_dbg), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("six_div_two", 1'b0, 8'd129, 23'h400000, 1'b0, 8'd128, 23'h000000,
              {1'b0, 8'd128, 23'h400000}, 1'b1);
        do_op("ovf_255", 1'b0, 8'd255, 23'h0, 1'b0, 8'd127, 23'h0, {1'b0, 8'hFE, 23'h7FFFFF}, 1'b1);
        do_op("max_254", 1'b1, 8'd254, 23'h0, 1'b0, 8'd127, 23'h0, {1'b1, 8'd254, 23'h0}, 1'b1);
        do_op("unf_zero", 1'b0, 8'd1, 23'h0, 1'b1, 8'd128, 23'h0, {1'b1, 8'h01, 23'h0}, 1'b1);
        do_op("unf_neg", 1'b1, 8'd1, 23'h0, 1'b1, 8'd200, 23'h0, {1'b0, 8'h01, 23'h0}, 1'b1);

        // backpressure: result must hold while inputs churn
        do_op("neg_two_thirds", 1'b1, 8'd127, 23'h0, 1'b0, 8'd127, 23'h400000,
              {1'b1, 8'd126, 23'h2AAAAA}, 1'b0);
        for (int i = 0; i < 10; i++) begin
            dut_if.in_valid = i[0];
            drive_ops(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 23'($urandom_range(0, 23'h7FFFFF)),
                      1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 23'($urandom_range(0, 23'h7FFFFF)));
            @(posedge clk); #1;
            check("bp_valid", 64'(dut_if.out_valid), 64'd1);
            check("bp_ready", 64'(dut_if.in_ready), 64'd0);
            check("bp_hold",  64'(result()), 64'({1'b1, 8'd126, 23'h2AAAAA}));
        end
        dut_if.in_valid  = 1'b0;
        dut_if.out_ready = 1'b1;
        @(posedge clk); #1;
        dut_if.out_ready = 1'b0;
        check("bp_release_valid", 64'(dut_if.out_valid), 64'd0);
        check("bp_release_ready", 64'(dut_if.in_ready), 64'd1);

        // reset in the 10th CALC cycle
        drive_ops(1'b0, 8'd129, 23'h400000, 1'b0, 8'd128, 23'h0);
        dut_if.in_valid = 1'b1;
        @(posedge clk); #1;
        dut_if.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_state",  64'(state_dbg), 64'd0);
        check("abort_ready",  64'(dut_if.in_ready), 64'd1);
        check("abort_valid",  64'(dut_if.out_valid), 64'd0);
        check("abort_result", 64'(result()), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        rises = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (dut_if.out_valid) rises++;
        end
        check("abort_no_result", 64'(rises), 64'd0);
        do_op("after_reset", 1'b0, 8'd129, 23'h400000, 1'b0, 8'd128, 23'h000000,
              {1'b0, 8'd128, 23'h400000}, 1'b1);

        // back-to-back issue with in_valid and out_ready held high
        sb_en = 1'b1;
        dut_if.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sx = 1'($urandom_range(0, 1));
            sy = 1'($urandom_range(0, 1));
            ex = 8'($urandom_range(90, 160));
            ey = 8'($urandom_range(90, 160));
            mx = 23'($urandom_range(0, 23'h7FFFFF));
            my = 23'($urandom_range(0, 23'h7FFFFF));
            drive_ops(sx, ex, mx, sy, ey, my);
            exp_q.push_back(golden(sx, ex, mx, sy, ey, my));
            dut_if.in_valid = 1'b1;
            n = 0;
            while (!dut_if.in_ready && n < 60) begin
                @(posedge clk); #1;
                n++;
            end
            check("b2b_in_ready", 64'(dut_if.in_ready), 64'd1);
            @(posedge clk); #1;
            acc[k] = cyc;
        end
        dut_if.in_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_drain", 64'(exp_q.size()), 64'd0);
        check("b2b_issue_1", 64'(acc[1] - acc[0]), 64'd28);
        check("b2b_issue_2", 64'(acc[2] - acc[1]), 64'd28);
        @(posedge clk); #1;
        sb_en = 1'b0;
        dut_if.out_ready = 1'b0;

        // final report
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fp_div_iter.md
# fp_div_iter

Iterative single-precision floating-point divider: the inverse operation to the team's combinational FP multiplier. It consumes the same split-field operand format (sign, 8-bit biased exponent, 23-bit stored mantissa) and applies the same saturation rules for out-of-range exponents. It computes X / Y with one radix-2 restoring-division step per clock. Operands and results use a valid/ready handshake so the block can sit between pipeline stages of the approximate-arithmetic datapath.

## Interface
- MANTISSA_WIDTH, 23, stored mantissa bits; implicit leading 1 added internally.
- EXP_WIDTH, 8, biased exponent bits; BIAS = 2^(EXP_WIDTH-1)-1 (127).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- sign_x, sign_y  input  1  operand signs; X is the dividend.
- exp_x, exp_y  input  EXP_WIDTH  biased exponents.
- mantissa_x, mantissa_y  input  MANTISSA_WIDTH  stored mantissas.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sign_out  output  1  registered result sign.
- exp_out  output  EXP_WIDTH  registered result exponent.
- mantissa_out  output  MANTISSA_WIDTH  registered result mantissa.

## Operation
- Operand handling:
  - All operands are treated as normalized, with significand {1, mantissa}.
  - There is no zero, denormal, infinity or NaN decoding. exp=0 or exp=255 inputs are computed arithmetically like any other value.
- States:
  - IDLE: in_ready=1. On in_valid && in_ready, capture the operands, set R = Mx (the 24-bit dividend significand), set the step counter to MANTISSA_WIDTH+1 (24), and go to CALC.
  - CALC: each cycle, if R >= My then q[cnt]=1 and R = R - My, else q[cnt]=0. Then R = R << 1 and cnt decrements.
    - R is MANTISSA_WIDTH+2 (25) bits wide.
    - After the cnt=0 step, go to NORM. This is 25 steps in total; q = floor(Mx * 2^24 / My).
  - NORM: normalize the quotient, compute the exponent, saturate, register the outputs, set out_valid=1, and go to DONE.
  - DONE: hold all outputs stable. On out_ready, clear out_valid and go to IDLE.
- Normalization:
  - If q[24]=1: mantissa = q[23:1], adj = 0.
  - Else: mantissa = q[22:0], adj = 1.
  - The quotient is truncated; there is no rounding.
- Exponent arithmetic uses 10-bit two's complement: e = {2'b0,exp_x} - {2'b0,exp_y} + BIAS - adj. The range is -129..382.
- Saturation:
  - Overflow (e >= 255): exp_out = 8'hFE, mantissa_out = all ones.
  - Underflow (e <= 0, i.e. e[9]=1 or e=0): exp_out = 8'h01, mantissa_out = 0.
  - Otherwise: exp_out = e[7:0] and mantissa_out = the normalized mantissa.
- sign_out = sign_x ^ sign_y always, including in saturated cases.

## Timing
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, sign_out = 0, exp_out = 0, mantissa_out = 0, R and q cleared.
- Latency:
  - The acceptance edge is T0. CALC steps occur on edges T1..T25; NORM registers on T26.
  - out_valid is high from T26 (MANTISSA_WIDTH+3 edges after acceptance).
  - The earliest next acceptance is the edge after the out_ready handshake, giving a 28-cycle minimum issue interval.
- in_ready is low in CALC, NORM and DONE. in_valid in those states is ignored, and the operand inputs may change freely.
- Outputs change only at the NORM edge. While out_valid && !out_ready, they are bit-stable.
- Reset asserted in any state aborts the operation immediately: no result is produced and the registers return to their reset values.

## Test plan
- 6.0/2.0: x = (0, 129, 0x400000), y = (0, 128, 0) -> after 26 edges, out_valid=1 with sign 0, exp 128, mantissa 0x400000.
- -1.0/1.5: x = (1, 127, 0), y = (0, 127, 0x400000) -> sign 1, exp 126, mantissa 0x2AAAAA (truncated 2/3).
- Overflow/underflow boundaries, all with mantissas 0:
  - exp_x=255, exp_y=127 -> exp 0xFE, mantissa 0x7FFFFF.
  - exp_x=254, exp_y=127 -> exp 254, mantissa 0.
  - exp_x=1, exp_y=128 -> exp 0x01, mantissa 0.
  - exp_x=1, exp_y=200 -> exp 0x01, mantissa 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, and toggle in_valid and the operands meanwhile -> outputs stable, in_ready=0. Then pulse out_ready -> out_valid falls, in_ready=1 on the next cycle.
- Mid-operation reset: assert rst_n=0 at the 10th CALC cycle -> all outputs at reset values, out_valid never rises. After release, 6.0/2.0 completes correctly.
- Back-to-back: hold in_valid=1 and out_ready=1 over three random operand pairs -> each result matches a golden truncating model, with a 28-cycle issue interval.
